// File: rtl/branch_checkpoint_buffer.sv
// Tag-addressed branch checkpoint buffer: tracks in-flight branches, drives RAT copy/paste, retires in order.
// Optional BB_RESOLVE_PC_CHECK_EN adds a resolve PC cross-check with a sticky error flag.

module branch_checkpoint_buffer_entry #(
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_alloc,
  input  logic [PC_W-1:0] i_alloc_pc,
  input  logic            i_resolve,
  input  logic            i_squash,
  input  logic            i_retire,
  output logic            o_valid,
  output logic            o_resolved,
  output logic [PC_W-1:0] o_pc
);
  logic            r_valid;
  logic            r_resolved;
  logic [PC_W-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_resolved <= 1'b0;
      r_pc       <= '0;
    end else if (i_clr) begin
      r_valid    <= 1'b0;
      r_resolved <= 1'b0;
    end else if (i_alloc) begin
      r_valid    <= 1'b1;
      r_resolved <= 1'b0;
      r_pc       <= i_alloc_pc;
    end else begin
      if (i_squash || i_retire) r_valid <= 1'b0;
      if (i_resolve)            r_resolved <= 1'b1;
    end
  end

  assign o_valid    = r_valid;
  assign o_resolved = r_resolved;
  assign o_pc       = r_pc;
endmodule

module branch_checkpoint_buffer #(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5,
  parameter int PC_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_alloc_valid,
  input  logic [PC_W-1:0]  i_alloc_pc,
  output logic             o_alloc_ready,
  output logic [PTR_W-1:0] o_alloc_tag,
  output logic             o_copy_rat,
  input  logic             i_resolve_valid,
  input  logic [PTR_W-1:0] i_resolve_tag,
  input  logic             i_resolve_mispredict,
`ifdef BB_RESOLVE_PC_CHECK_EN
  input  logic [PC_W-1:0]  i_resolve_pc,
  output logic             o_resolve_err,
`endif
  output logic             o_paste_rat,
  output logic [PTR_W-1:0] o_paste_tag,
  output logic             o_retire_valid,
  output logic [PTR_W-1:0] o_retire_tag,
  output logic [PTR_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_copy_rat, r_paste_rat, r_retire_valid;
  logic [PTR_W-1:0] r_alloc_tag, r_paste_tag, r_retire_tag;

  logic [DEPTH-1:0]           w_valid, w_resolved;
  logic [DEPTH-1:0][PC_W-1:0] w_pc;
  logic [DEPTH-1:0]           w_alloc_we, w_res_we, w_squash, w_ret_we;

  logic             w_res_hit, w_pc_ok, w_res_acc, w_mis, w_alloc_acc, w_retire;
  logic [PTR_W-1:0] w_tag_pos;

  assign o_full        = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty       = (r_count == '0);
  assign o_alloc_ready = !o_full && !(i_resolve_valid && i_resolve_mispredict) && !i_flush;

  assign w_res_hit = i_resolve_valid && w_valid[i_resolve_tag] && !w_resolved[i_resolve_tag];
`ifdef BB_RESOLVE_PC_CHECK_EN
  assign w_pc_ok = (i_resolve_pc == w_pc[i_resolve_tag]);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^w_pc;
  assign w_pc_ok     = 1'b1;
`endif
  assign w_res_acc   = !i_flush && w_res_hit && w_pc_ok;
  assign w_mis       = w_res_acc && i_resolve_mispredict;
  assign w_alloc_acc = i_alloc_valid && o_alloc_ready;
  assign w_retire    = !i_flush && w_valid[r_head] && w_resolved[r_head];
  // Age of the resolved entry relative to head; anything older-positioned survives a squash.
  assign w_tag_pos   = i_resolve_tag - r_head;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PTR_W-1:0] w_pos;
    assign w_pos         = PTR_W'(g) - r_head;
    assign w_alloc_we[g] = w_alloc_acc && (r_tail == PTR_W'(g));
    assign w_res_we[g]   = w_res_acc && (i_resolve_tag == PTR_W'(g));
    assign w_squash[g]   = w_mis && (w_pos > w_tag_pos);
    assign w_ret_we[g]   = w_retire && (r_head == PTR_W'(g));

    branch_checkpoint_buffer_entry #(.PC_W(PC_W)) u_ent (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (i_flush),
      .i_alloc    (w_alloc_we[g]),
      .i_alloc_pc (i_alloc_pc),
      .i_resolve  (w_res_we[g]),
      .i_squash   (w_squash[g]),
      .i_retire   (w_ret_we[g]),
      .o_valid    (w_valid[g]),
      .o_resolved (w_resolved[g]),
      .o_pc       (w_pc[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_copy_rat     <= 1'b0;
      r_paste_rat    <= 1'b0;
      r_retire_valid <= 1'b0;
      r_alloc_tag    <= '0;
      r_paste_tag    <= '0;
      r_retire_tag   <= '0;
    end else if (i_flush) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_copy_rat     <= 1'b0;
      r_paste_rat    <= 1'b0;
      r_retire_valid <= 1'b0;
    end else begin
      r_copy_rat     <= w_alloc_acc;
      r_paste_rat    <= w_mis;
      r_retire_valid <= w_retire;
      // alloc_ready already excludes mispredict cycles, so these tail writes never collide
      if (w_alloc_acc) begin
        r_alloc_tag <= r_tail;
        r_tail      <= r_tail + PTR_W'(1);
      end
      if (w_mis) begin
        r_paste_tag <= i_resolve_tag;
        r_tail      <= i_resolve_tag + PTR_W'(1);
      end
      if (w_retire) begin
        r_retire_tag <= r_head;
        r_head       <= r_head + PTR_W'(1);
      end
      if (w_mis)
        r_count <= (PTR_W+1)'(w_tag_pos) + (PTR_W+1)'(1) - (PTR_W+1)'(w_retire);
      else
        r_count <= r_count + (PTR_W+1)'(w_alloc_acc) - (PTR_W+1)'(w_retire);
    end
  end

`ifdef BB_RESOLVE_PC_CHECK_EN
  logic r_resolve_err;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush)
      r_resolve_err <= 1'b0;
    else if (i_resolve_valid && !w_pc_ok)
      r_resolve_err <= 1'b1;
  end
  assign o_resolve_err = r_resolve_err;
`endif

  assign o_count        = r_count;
  assign o_copy_rat     = r_copy_rat;
  assign o_paste_rat    = r_paste_rat;
  assign o_retire_valid = r_retire_valid;
  assign o_alloc_tag    = r_alloc_tag;
  assign o_paste_tag    = r_paste_tag;
  assign o_retire_tag   = r_retire_tag;
endmodule

// File: tb/tb_branch_checkpoint_buffer.sv
// Bench for branch_checkpoint_buffer: directed plan plus random traffic against an in-order queue model.
module tb_branch_checkpoint_buffer;
  localparam int DEPTH = 32;
  localparam int PTR_W = 5;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             rst, flush, alloc_valid, resolve_valid, resolve_mispredict;
  logic [PC_W-1:0]  alloc_pc, resolve_pc;
  logic [PTR_W-1:0] resolve_tag;
  logic             alloc_ready, copy_rat, paste_rat, retire_valid, full, empty, resolve_err;
  logic [PTR_W-1:0] alloc_tag, paste_tag, retire_tag;
  logic [PTR_W:0]   count;

  always #5 clk = ~clk;

  branch_checkpoint_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(PC_W)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_flush             (flush),
    .i_alloc_valid       (alloc_valid),
    .i_alloc_pc          (alloc_pc),
    .o_alloc_ready       (alloc_ready),
    .o_alloc_tag         (alloc_tag),
    .o_copy_rat          (copy_rat),
    .i_resolve_valid     (resolve_valid),
    .i_resolve_tag       (resolve_tag),
    .i_resolve_mispredict(resolve_mispredict),
`ifdef BB_RESOLVE_PC_CHECK_EN
    .i_resolve_pc        (resolve_pc),
    .o_resolve_err       (resolve_err),
`endif
    .o_paste_rat         (paste_rat),
    .o_paste_tag         (paste_tag),
    .o_retire_valid      (retire_valid),
    .o_retire_tag        (retire_tag),
    .o_count             (count),
    .o_full              (full),
    .o_empty             (empty)
  );
`ifndef BB_RESOLVE_PC_CHECK_EN
  assign resolve_err = 1'b0;
`endif

  // Model: program-order list of live branches, oldest first.
  typedef struct {int tag; bit res;} ent_t;
  ent_t q[$];
  int   m_tail;
  logic [PC_W-1:0] mpc [DEPTH];
  bit   e_copy, e_paste, e_ret;
  int   e_alloc_tag, e_paste_tag, e_ret_tag;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("copy_rat",     32'(copy_rat),     32'(e_copy));
    chk("paste_rat",    32'(paste_rat),    32'(e_paste));
    chk("retire_valid", 32'(retire_valid), 32'(e_ret));
    chk("alloc_tag",    32'(alloc_tag),    32'(e_alloc_tag));
    chk("paste_tag",    32'(paste_tag),    32'(e_paste_tag));
    chk("retire_tag",   32'(retire_tag),   32'(e_ret_tag));
    chk("count",        32'(count),        32'(q.size()));
    chk("full",         32'(full),         32'(q.size() == DEPTH));
    chk("empty",        32'(empty),        32'(q.size() == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_pc = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0; resolve_pc = '0;
    @(posedge clk); @(posedge clk); #1;
    q.delete(); m_tail = 0;
    e_copy = 0; e_paste = 0; e_ret = 0; e_alloc_tag = 0; e_paste_tag = 0; e_ret_tag = 0;
    chk_outputs();
    rst = 1'b0;
  endtask

  task automatic step(input bit av, input logic [PC_W-1:0] pc, input bit rv, input int tag,
                      input bit mis, input bit fl);
    bit ready, ret;
    int k;
    @(negedge clk);
    alloc_valid = av; alloc_pc = pc; resolve_valid = rv; resolve_tag = PTR_W'(tag);
    resolve_mispredict = mis; flush = fl; resolve_pc = mpc[tag % DEPTH];
    #1;
    ready = (q.size() != DEPTH) && !(rv && mis) && !fl;
    chk("alloc_ready", 32'(alloc_ready), 32'(ready));
    e_copy = 0; e_paste = 0; e_ret = 0;
    if (fl) begin
      q.delete(); m_tail = 0;
    end else begin
      ret = (q.size() > 0) && q[0].res;
      k = -1;
      if (rv) for (int i = 0; i < q.size(); i++) if (q[i].tag == tag) k = i;
      if (k >= 0 && !q[k].res) begin
        ent_t e = q[k];
        e.res = 1; q[k] = e;
        if (mis) begin
          while (q.size() > k + 1) void'(q.pop_back());
          m_tail = (tag + 1) % DEPTH;
          e_paste = 1; e_paste_tag = tag;
        end
      end
      if (ret) begin
        e_ret = 1; e_ret_tag = q[0].tag; void'(q.pop_front());
      end
      if (av && ready) begin
        q.push_back('{tag: m_tail, res: 1'b0});
        mpc[m_tail] = pc;
        e_copy = 1; e_alloc_tag = m_tail;
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk); #1;
    chk_outputs();
  endtask

  task automatic alloc(input logic [PC_W-1:0] pc); step(1, pc, 0, 0, 0, 0); endtask
  task automatic resolve(input int tag, input bit mis); step(0, '0, 1, tag, mis, 0); endtask
  task automatic idle(); step(0, '0, 0, 0, 0, 0); endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mpc[i] = '0;

    // In-order retire after out-of-order correct resolves
    do_reset();
    alloc(32'h100); alloc(32'h104); alloc(32'h108);
    chk("plan1_count", 32'(count), 32'd3);
    resolve(1, 0); resolve(0, 0); resolve(2, 0);
    idle(); idle(); idle();
    chk("plan1_empty", 32'(empty), 32'd1);

    // Mispredict squash and ignored resolve of a squashed tag
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32'h200 + 32'(4 * i));
    resolve(1, 1);
    chk("plan2_paste_tag", 32'(paste_tag), 32'd1);
    resolve(3, 0);
    idle(); idle();
    chk("plan2_count", 32'(count), 32'd2);

    // Full, drop, wrap and wrap-aware squash
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(4 * i));
    alloc(32'hdead);
    resolve(0, 0);
    idle();
    chk("plan3_not_full", 32'(full), 32'd0);
    alloc(32'h2000);
    chk("plan3_wrap_tag", 32'(alloc_tag), 32'd0);
    resolve(DEPTH - 1, 1);
    chk("plan3_sq_count", 32'(count), 32'(DEPTH - 1));
    resolve(0, 0);
    idle();

    // Alloc colliding with a mispredict is dropped
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32'h300 + 32'(4 * i));
    step(1, 32'h400, 1, 2, 1, 0);
    alloc(32'h404);
    chk("plan4_tag", 32'(alloc_tag), 32'd3);

    // Flush mid-resolve
    do_reset();
    for (int i = 0; i < 6; i++) alloc(32'h500 + 32'(4 * i));
    resolve(0, 0);
    step(1, 32'h600, 1, 3, 1, 1);
    idle();

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit av, rv, mis, fl;
      int tag;
      av  = ($urandom_range(99) < 60);
      rv  = ($urandom_range(99) < 50);
      mis = ($urandom_range(99) < 12);
      fl  = ($urandom_range(99) < 2);
      if (q.size() > 0 && $urandom_range(3) != 0) tag = q[$urandom_range(q.size() - 1)].tag;
      else tag = int'($urandom_range(DEPTH - 1));
      step(av, $urandom, rv, tag, mis, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_checkpoint_buffer.md
Name: branch_checkpoint_buffer

Overview:
- Parametrised, tag-addressed successor to the branch buffer. Tracks every in-flight branch/jump (opcodes 1100011, 1101111, 1100111) from dispatch to resolution.
- Each entry is a RAT checkpoint slot. Allocation requests a RAT copy. A mispredicted resolution requests a RAT paste and squashes all younger entries. Correct resolutions retire in order from head.
- Sits between decode/rename (allocate) and the branch execution unit (resolve). Exception and mret flush it entirely.

Parameters:
- DEPTH, 32, number of entries; power of two, at least 4.
- PTR_W, 5, log2(DEPTH); width of tags and pointers.
- PC_W, 32, stored PC width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  exception_sig | mret_sig; clears the buffer
- alloc_valid  in  1  a branch/jump is dispatched this cycle
- alloc_pc  in  PC_W  PC of the dispatched branch
- alloc_ready  out  1  combinational; !full && !(resolve_valid && resolve_mispredict) && !flush
- alloc_tag  out  PTR_W  tag given to the last accepted allocation (registered)
- copy_rat  out  1  one-cycle pulse; RAT must checkpoint into slot alloc_tag
- resolve_valid  in  1  execution unit resolves a branch
- resolve_tag  in  PTR_W  tag being resolved
- resolve_mispredict  in  1  1 = taken/target mismatch (PCSrc)
- paste_rat  out  1  one-cycle pulse; RAT must restore checkpoint paste_tag
- paste_tag  out  PTR_W  checkpoint to restore
- retire_valid  out  1  one-cycle pulse; entry retire_tag released
- retire_tag  out  PTR_W  retired tag (free list may release the checkpoint)
- count  out  PTR_W+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- State: pc[DEPTH], valid[DEPTH], resolved[DEPTH], head, tail, count. All update on posedge clk.
- Reset (rst=1): head = tail = 0, count = 0, all valid/resolved = 0. Outputs: copy_rat = paste_rat = retire_valid = 0; alloc_tag = paste_tag = retire_tag = 0.
- Priority: rst > flush > mispredict > (allocate, correct resolve, retire).
- flush: same clear as reset, except alloc_tag, paste_tag and retire_tag hold their values. Pulses are 0 the next cycle. Any same-cycle alloc/resolve is ignored.
- Allocate: when alloc_valid && alloc_ready:
  - pc[tail] = alloc_pc, valid = 1, resolved = 0.
  - alloc_tag = tail and copy_rat = 1 in the next cycle (latency 1).
  - tail = tail + 1 mod DEPTH (natural wrap at PTR_W bits).
  - When alloc_valid && !alloc_ready, the request is dropped. The upstream stage must stall.
- Resolve is ignored if valid[resolve_tag] = 0 or resolved[resolve_tag] = 1.
- Correct resolve (mispredict = 0): resolved[tag] = 1.
- Mispredict resolve:
  - resolved[tag] = 1.
  - Every entry strictly younger than tag (tag+1 up to old tail-1, wrap-aware) gets valid = 0.
  - tail = tag + 1.
  - count = ((tag − head) mod DEPTH) + 1 − retire_this_cycle.
  - paste_rat = 1 and paste_tag = tag in the next cycle. copy_rat = 0 that cycle.
- Retire: if valid[head] && resolved[head] (registered flags):
  - valid[head] = 0, head++.
  - retire_valid = 1, retire_tag = head (old) in the next cycle.
  - At most one retire per cycle. A resolve becomes retire-eligible one cycle after it is accepted.
- Count: count_next = count + alloc_accepted − retired, except on mispredict (rule above).
  - full and empty are derived from the registered count.
  - When full, alloc is blocked even if a retire occurs the same cycle.
- Boundaries:
  - A mispredict on the youngest entry squashes nothing; tail is unchanged.
  - A mispredict on head leaves count = 1, minus 1 if head retires that cycle (impossible, since head is still unresolved).
  - Wrap-around with tail < head must squash correctly.
- Pulses (copy_rat, paste_rat, retire_valid) are exactly one cycle wide. They may assert in the same cycle, except that copy_rat and paste_rat never do.

Optional Feature:
- Macro BB_RESOLVE_PC_CHECK_EN.
- When defined:
  - Extra input resolve_pc (PC_W) and extra output resolve_err (1, sticky, cleared by rst/flush).
  - A resolve whose resolve_pc != pc[resolve_tag] is ignored entirely and sets resolve_err.
- When undefined: no extra ports; resolve trusts resolve_tag alone.

Test Plan:
- Reset then 3 allocs with PCs 0x100, 0x104, 0x108 → alloc_tag 0, 1, 2 with copy_rat pulses on cycles 1–3; count = 3.
- Resolve tags 1, 0, 2 correct, in that order → retire_valid tags 0, 1, 2 in order, never out of order; empty = 1 afterwards.
- 5 allocs (tags 0–4), mispredict tag 1 → paste_rat with paste_tag = 1 next cycle; tail = 2, count = 2. A later resolve of tag 3 is ignored.
- DEPTH allocs → full = 1, alloc_ready = 0; extra alloc dropped. Retire tag 0 → full = 0 next cycle. Next alloc gets tag 0 (wrap). Mispredict at tag DEPTH−1 with head = 1 → tag 0 squashed, count = DEPTH−1.
- Same cycle alloc_valid + mispredict tag 2 (tail = 5) → alloc dropped (alloc_ready = 0); tail = 3, no copy_rat.
- flush with 6 entries mid-resolve → next cycle count = 0, empty = 1, no paste_rat/retire_valid pulses.
